pll_lock_supervisor: RTL and testbench

- Sits on the far side of the PLL's rst/locked interface and drives the PLL's `rst` input.
- Consumes the PLL's asynchronous `locked` output and produces the core's reset and ready signals.
- Pulses the PLL reset at start-up and retries the PLL when lock does not arrive within a timeout.
- Holds the system in reset until lock has been continuously stable; re-sequences everything on lock loss.

---
 rtl/pll_sup_pkg.sv | 25 ++
 rtl/pll_lock_sync.sv | 26 ++
 rtl/pll_lock_supervisor.sv | 140 ++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
// Holds the supervisor state encoding and the saturating event-counter helper.
package pll_sup_pkg;

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABILIZE = 2'd2,
        RUN       = 2'd3
    } pll_state_t;

    localparam logic [7:0] SAT_MAX = 8'hFF;

    // Event counters stick at SAT_MAX so a flapping PLL never reads back as healthy.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        logic [7:0] result;
        if (value == SAT_MAX) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser bringing the PLL's asynchronous locked flag into the reference clock domain.
// Both stages clear on the synchronous reset so a stale lock is never seen after reset.
module pll_lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta_r;
    logic sync_r;

    // Double-register the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
        end
    end

    assign sync_out = sync_r;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences the PLL reset, waits for a stable lock, and gates the core reset/ready on it.
// All outputs are decoded from the next state so they move on the same edge as the state.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned CNT_W         = 20
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic [7:0] retry_count,
    output logic [7:0] loss_count
);

    localparam logic [CNT_W-1:0] RST_TERM    = CNT_W'(RST_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] LOCK_TERM   = CNT_W'(LOCK_TIMEOUT - 32'd1);
    localparam logic [CNT_W-1:0] STABLE_TERM = CNT_W'(STABLE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1'b1);

    pll_state_t       state_r;
    pll_state_t       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             lock_s;
    logic             retry_inc_s;
    logic             loss_inc_s;
    logic             pll_rst_r;
    logic             sys_reset_r;
    logic             ready_r;
    logic [7:0]       retry_r;
    logic [7:0]       loss_r;

    pll_lock_sync u_sync (
        .clk      (refclk),
        .rst      (rst),
        .async_in (pll_locked),
        .sync_out (lock_s)
    );

    // Next-state selection; a deasserted lock always takes priority over a terminal count.
    always_comb begin
        state_nxt_s = state_r;
        retry_inc_s = 1'b0;
        loss_inc_s  = 1'b0;
        case (state_r)
            RESET_PLL: begin
                if (cnt_r == RST_TERM) begin
                    state_nxt_s = WAIT_LOCK;
                end else begin
                    state_nxt_s = RESET_PLL;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt_s = STABILIZE;
                end else if (cnt_r == LOCK_TERM) begin
                    state_nxt_s = RESET_PLL;
                    retry_inc_s = 1'b1;
                end else begin
                    state_nxt_s = WAIT_LOCK;
                end
            end
            STABILIZE: begin
                if (!lock_s) begin
                    state_nxt_s = WAIT_LOCK;
                end else if (cnt_r == STABLE_TERM) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = STABILIZE;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_nxt_s = RESET_PLL;
                    loss_inc_s  = 1'b1;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = RESET_PLL;
            end
        endcase
    end

    // Shared cycle counter: restarts on every state change and idles at zero in RUN.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (state_nxt_s != state_r) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (state_r == RUN) begin
            cnt_nxt_s = CNT_ZERO;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end
    end

    // State, counter and registered output update.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_r     <= RESET_PLL;
            cnt_r       <= CNT_ZERO;
            pll_rst_r   <= 1'b1;
            sys_reset_r <= 1'b1;
            ready_r     <= 1'b0;
            retry_r     <= 8'd0;
            loss_r      <= 8'd0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            pll_rst_r   <= (state_nxt_s == RESET_PLL);
            sys_reset_r <= (state_nxt_s != RUN);
            ready_r     <= (state_nxt_s == RUN);
            if (retry_inc_s) begin
                retry_r <= sat_inc(retry_r);
            end else begin
                retry_r <= retry_r;
            end
            if (loss_inc_s) begin
                loss_r <= sat_inc(loss_r);
            end else begin
                loss_r <= loss_r;
            end
        end
    end

    assign pll_rst     = pll_rst_r;
    assign sys_reset   = sys_reset_r;
    assign ready       = ready_r;
    assign retry_count = retry_r;
    assign loss_count  = loss_r;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed scoreboard bench for pll_lock_supervisor with RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8.
// Each step queues the expected outputs, advances the clock, then pops and compares.
module tb_pll_lock_supervisor;
    import pll_sup_pkg::*;

    typedef struct {
        string      tag;
        pll_state_t st;
        logic       prst;
        logic       srst;
        logic       rdy;
        logic [7:0] rc;
        logic [7:0] lc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic [7:0] retry_count;
    logic [7:0] loss_count;

    exp_t        sb_q[$];
    int unsigned n_checks;
    int unsigned n_fail;

    pll_lock_supervisor #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .CNT_W         (20)
    ) dut (
        .refclk      (clk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .sys_reset   (sys_reset),
        .ready       (ready),
        .retry_count (retry_count),
        .loss_count  (loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_pop();
        exp_t        e;
        logic [20:0] obs;
        logic [20:0] exp_v;
        e     = sb_q.pop_front();
        obs   = {dut.state_r, pll_rst, sys_reset, ready, retry_count, loss_count};
        exp_v = {e.st, e.prst, e.srst, e.rdy, e.rc, e.lc};
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed={st,prst,srst,rdy,rc,lc}=%h expected=%h", e.tag, obs, exp_v);
        end
    endtask

    task automatic step(input int n, input string tag, input pll_state_t st, input logic prst,
                        input logic srst, input logic rdy, input logic [7:0] rc, input logic [7:0] lc);
        exp_t e;
        e.tag = tag; e.st = st; e.prst = prst; e.srst = srst; e.rdy = rdy; e.rc = rc; e.lc = lc;
        sb_q.push_back(e);
        tick(n);
        check_pop();
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp_b);
        n_checks++;
        assert (obs === exp_b) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_b);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        pll_locked = 1'b0;

        // Power-up: reset state, then pll_rst held for exactly four edges after release.
        step(3, "reset_state", RESET_PLL, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
        check_bit("reset_lock_s", dut.lock_s, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (i < 4) step(1, "pwr_pll_rst", RESET_PLL, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
            else       step(1, "pwr_release", WAIT_LOCK, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
        end

        // Lock timeouts: retry 1..3 with pulse checks, then drive to saturation.
        step(31, "wait_hold", WAIT_LOCK, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
        step(1,  "timeout1",  RESET_PLL, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0);
        step(3,  "repulse1",  RESET_PLL, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0);
        step(1,  "rewait1",   WAIT_LOCK, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
        for (int r = 2; r <= 3; r++) begin
            step(32, "timeout_n", RESET_PLL, 1'b1, 1'b1, 1'b0, 8'(r), 8'd0);
            step(4,  "rewait_n",  WAIT_LOCK, 1'b0, 1'b1, 1'b0, 8'(r), 8'd0);
        end
        for (int r = 4; r <= 299; r++) tick(36);
        step(32, "retry_sat",  RESET_PLL, 1'b1, 1'b1, 1'b0, 8'd255, 8'd0);
        step(4,  "retry_sat2", WAIT_LOCK, 1'b0, 1'b1, 1'b0, 8'd255, 8'd0);

        // Reset in WAIT_LOCK clears counters, then one more timeout.
        rst = 1'b1;
        step(1, "rst_wait", RESET_PLL, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
        rst = 1'b0;
        step(4,  "rst_rel",   WAIT_LOCK, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
        step(32, "timeout_a", RESET_PLL, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0);
        step(4,  "rewait_a",  WAIT_LOCK, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);

        // Lock with a 3-cycle glitch; the drop coincides with STABILIZE terminal count.
        pll_locked = 1'b1;
        step(2, "lk_sync",   WAIT_LOCK, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
        step(1, "lk_stab",   STABILIZE, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
        step(5, "gl_cnt5",   STABILIZE, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
        pll_locked = 1'b0;
        step(2, "gl_still",  STABILIZE, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
        step(1, "gl_drop",   WAIT_LOCK, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
        pll_locked = 1'b1;
        step(2, "gl_wait",   WAIT_LOCK, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
        step(1, "gl_restab", STABILIZE, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
        step(7, "gl_hold",   STABILIZE, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
        step(1, "gl_run",    RUN,       1'b0, 1'b0, 1'b1, 8'd1, 8'd0);
        step(3, "run_hold",  RUN,       1'b0, 1'b0, 1'b1, 8'd1, 8'd0);

        // One-cycle lock loss in RUN, automatic relock.
        pll_locked = 1'b0;
        step(1, "loss_m",    RUN,       1'b0, 1'b0, 1'b1, 8'd1, 8'd0);
        pll_locked = 1'b1;
        step(1, "loss_m1",   RUN,       1'b0, 1'b0, 1'b1, 8'd1, 8'd0);
        step(1, "loss_rst",  RESET_PLL, 1'b1, 1'b1, 1'b0, 8'd1, 8'd1);
        step(3, "loss_pul",  RESET_PLL, 1'b1, 1'b1, 1'b0, 8'd1, 8'd1);
        step(1, "loss_wait", WAIT_LOCK, 1'b0, 1'b1, 1'b0, 8'd1, 8'd1);
        step(1, "loss_stab", STABILIZE, 1'b0, 1'b1, 1'b0, 8'd1, 8'd1);
        step(8, "loss_run",  RUN,       1'b0, 1'b0, 1'b1, 8'd1, 8'd1);

        // Long loss, then clean rising lock: STABILIZE at k+2, RUN at k+10.
        pll_locked = 1'b0;
        step(2, "l2_hold",   RUN,       1'b0, 1'b0, 1'b1, 8'd1, 8'd1);
        step(1, "l2_rst",    RESET_PLL, 1'b1, 1'b1, 1'b0, 8'd1, 8'd2);
        step(4, "l2_wait",   WAIT_LOCK, 1'b0, 1'b1, 1'b0, 8'd1, 8'd2);
        step(3, "l2_nolock", WAIT_LOCK, 1'b0, 1'b1, 1'b0, 8'd1, 8'd2);
        pll_locked = 1'b1;
        step(2, "nl_k1",     WAIT_LOCK, 1'b0, 1'b1, 1'b0, 8'd1, 8'd2);
        step(1, "nl_k2",     STABILIZE, 1'b0, 1'b1, 1'b0, 8'd1, 8'd2);
        step(7, "nl_k9",     STABILIZE, 1'b0, 1'b1, 1'b0, 8'd1, 8'd2);
        step(1, "nl_k10",    RUN,       1'b0, 1'b0, 1'b1, 8'd1, 8'd2);

        // Reach STABILIZE again, then reset mid-STABILIZE.
        pll_locked = 1'b0;
        step(1, "l3_m",      RUN,       1'b0, 1'b0, 1'b1, 8'd1, 8'd2);
        pll_locked = 1'b1;
        step(1, "l3_m1",     RUN,       1'b0, 1'b0, 1'b1, 8'd1, 8'd2);
        step(1, "l3_rst",    RESET_PLL, 1'b1, 1'b1, 1'b0, 8'd1, 8'd3);
        step(4, "l3_wait",   WAIT_LOCK, 1'b0, 1'b1, 1'b0, 8'd1, 8'd3);
        step(1, "l3_stab",   STABILIZE, 1'b0, 1'b1, 1'b0, 8'd1, 8'd3);
        step(2, "l3_stab2",  STABILIZE, 1'b0, 1'b1, 1'b0, 8'd1, 8'd3);
        rst = 1'b1;
        step(1, "mid_rst",   RESET_PLL, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
        check_bit("mid_rst_lock_s", dut.lock_s, 1'b0);
        rst = 1'b0;
        step(1, "mr_rel1",   RESET_PLL, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
        check_bit("mr_sync1", dut.lock_s, 1'b0);
        step(1, "mr_rel2",   RESET_PLL, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
        check_bit("mr_sync2", dut.lock_s, 1'b1);
        step(2, "mr_wait",   WAIT_LOCK, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
        step(1, "mr_stab",   STABILIZE, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);

        n_checks++;
        assert (sb_q.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain observed=%0d expected=0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
